pifo_enq_buffer: RTL and testbench

PIFO_ENQ_BUFFER -- requirements
Module: pifo_enq_buffer

---
 rtl/pifo_enq_buffer.sv | 93 +++++++++
 tb/tb_pifo_enq_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pifo_enq_buffer.sv
// rtl/pifo_enq_buffer.sv - circular FIFO that stages {rank, meta} entries in front of a PIFO
module pifo_enq_buffer #(
    parameter int RANK_WIDTH = 10,
    parameter int META_WIDTH = 20,
    parameter int L2_DEPTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RANK_WIDTH-1:0] in_rank,
    input  logic [META_WIDTH-1:0] in_meta,
    input  logic                  drop_en,
    output logic                  pifo_insert,
    output logic [RANK_WIDTH-1:0] pifo_rank,
    output logic [META_WIDTH-1:0] pifo_meta,
    input  logic                  pifo_busy,
    input  logic                  pifo_full,
    output logic [L2_DEPTH:0]     occupancy,
    output logic [15:0]           drop_cnt,
    output logic [L2_DEPTH:0]     max_occ
);
    localparam int DEPTH   = 2 ** L2_DEPTH;
    localparam int ENTRY_W = RANK_WIDTH + META_WIDTH;
    localparam logic [L2_DEPTH:0] OCC_FULL = (L2_DEPTH + 1)'(DEPTH);

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [L2_DEPTH-1:0] r_rd_ptr;
    logic [L2_DEPTH-1:0] r_wr_ptr;
    logic [L2_DEPTH:0]   r_occ;
    logic [15:0]         r_drop_cnt;
    logic [L2_DEPTH:0]   r_max_occ;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    assign w_full  = (r_occ == OCC_FULL);
    assign w_empty = (r_occ == '0);

    // in_ready deliberately ignores the pop so a full buffer never stalls on PIFO timing
    assign in_ready = ~w_full | drop_en;
    assign w_push   = in_valid & in_ready & ~w_full;
    assign w_drop   = in_valid & w_full & drop_en;
    assign w_pop    = ~w_empty & ~pifo_busy & ~pifo_full;

    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign pifo_insert = w_pop;
    assign pifo_rank   = w_head[ENTRY_W-1:META_WIDTH];
    assign pifo_meta   = w_head[META_WIDTH-1:0];

    assign occupancy = r_occ;
    assign drop_cnt  = r_drop_cnt;
    assign max_occ   = r_max_occ;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_rank, in_meta};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_occ      <= '0;
            r_drop_cnt <= '0;
            r_max_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            // tracks the registered occupancy, so the mark trails occupancy by one cycle
            if (r_occ > r_max_occ) begin
                r_max_occ <= r_occ;
            end
        end
    end
endmodule

// File: tb/tb_pifo_enq_buffer.sv
// tb/tb_pifo_enq_buffer.sv - directed self-checking bench for pifo_enq_buffer
module tb_pifo_enq_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_rank;
    logic [19:0] in_meta;
    logic        drop_en;
    logic        pifo_insert;
    logic [9:0]  pifo_rank;
    logic [19:0] pifo_meta;
    logic        pifo_busy;
    logic        pifo_full;
    logic [3:0]  occupancy;
    logic [15:0] drop_cnt;
    logic [3:0]  max_occ;

    int n_checks = 0;
    int n_fails  = 0;

    pifo_enq_buffer #(.RANK_WIDTH(10), .META_WIDTH(20), .L2_DEPTH(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rank(in_rank), .in_meta(in_meta),
        .drop_en(drop_en),
        .pifo_insert(pifo_insert), .pifo_rank(pifo_rank), .pifo_meta(pifo_meta),
        .pifo_busy(pifo_busy), .pifo_full(pifo_full),
        .occupancy(occupancy), .drop_cnt(drop_cnt), .max_occ(max_occ)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_rank  = 10'(base + i);
            in_meta  = 20'(base + i + 100);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            #2;
            check_eq("drain_insert", 32'(pifo_insert), 32'd1);
            check_eq("drain_rank", 32'(pifo_rank), 32'(first + i));
            check_eq("drain_meta", 32'(pifo_meta), 32'(first + i + 100));
            tick();
        end
    endtask

    logic [29:0] q[$];
    int          sent;
    int          got_cnt;
    logic        exp_ins;
    logic [29:0] ent;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rank = '0; in_meta = '0;
        drop_en = 1'b0; pifo_busy = 1'b0; pifo_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #2;
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_insert", 32'(pifo_insert), 32'd0);
        check_eq("rst_rank", 32'(pifo_rank), 32'd0);
        check_eq("rst_meta", 32'(pifo_meta), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_max", 32'(max_occ), 32'd0);
        tick();

        // basic flow: 5,3,9 out in order starting one cycle after the first push
        in_valid = 1'b1; in_rank = 10'd5; in_meta = 20'd105;
        #2 check_eq("bf_lat0", 32'(pifo_insert), 32'd0);
        tick();
        in_rank = 10'd3; in_meta = 20'd103;
        #2 check_eq("bf_ins1", 32'(pifo_insert), 32'd1);
        check_eq("bf_rank1", 32'(pifo_rank), 32'd5);
        tick();
        in_rank = 10'd9; in_meta = 20'd109;
        #2 check_eq("bf_ins2", 32'(pifo_insert), 32'd1);
        check_eq("bf_rank2", 32'(pifo_rank), 32'd3);
        check_eq("bf_occ2", 32'(occupancy), 32'd1);
        tick();
        in_valid = 1'b0;
        #2 check_eq("bf_ins3", 32'(pifo_insert), 32'd1);
        check_eq("bf_rank3", 32'(pifo_rank), 32'd9);
        tick();
        #2 check_eq("bf_idle", 32'(pifo_insert), 32'd0);
        check_eq("bf_occ", 32'(occupancy), 32'd0);
        tick();

        // backpressure: 8 entries fill the buffer
        pifo_busy = 1'b1;
        fill(10, 8);
        #2 check_eq("bp_occ", 32'(occupancy), 32'd8);
        check_eq("bp_ready", 32'(in_ready), 32'd0);
        check_eq("bp_insert", 32'(pifo_insert), 32'd0);
        tick();
        #2 check_eq("bp_max", 32'(max_occ), 32'd8);
        tick();
        in_valid = 1'b1; in_rank = 10'd50; in_meta = 20'd50;
        #2 check_eq("bp_block_ready", 32'(in_ready), 32'd0);
        tick();
        #2 check_eq("bp_block_occ", 32'(occupancy), 32'd8);
        check_eq("bp_block_drop", 32'(drop_cnt), 32'd0);
        tick();

        // drops while full
        drop_en = 1'b1; in_rank = 10'd51;
        #2 check_eq("drop_ready", 32'(in_ready), 32'd1);
        tick(); tick(); tick();
        in_valid = 1'b0; drop_en = 1'b0;
        #2 check_eq("drop_cnt3", 32'(drop_cnt), 32'd3);
        check_eq("drop_occ", 32'(occupancy), 32'd8);
        tick();

        // pop at full with a blocked push, then drain in order
        pifo_busy = 1'b0; in_valid = 1'b1; in_rank = 10'd60; in_meta = 20'd60;
        #2 check_eq("fp_insert", 32'(pifo_insert), 32'd1);
        check_eq("fp_rank", 32'(pifo_rank), 32'd10);
        check_eq("fp_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        #2 check_eq("fp_occ7", 32'(occupancy), 32'd7);
        drain(11, 7);
        #2 check_eq("fp_empty", 32'(occupancy), 32'd0);
        tick();

        // pifo_full holds off inserts; then push+pop at occupancy 4
        pifo_busy = 1'b1;
        fill(20, 4);
        pifo_busy = 1'b0; pifo_full = 1'b1;
        #2 check_eq("pf_insert", 32'(pifo_insert), 32'd0);
        tick();
        #2 check_eq("pf_occ", 32'(occupancy), 32'd4);
        tick();
        pifo_full = 1'b0; in_valid = 1'b1; in_rank = 10'd24; in_meta = 20'd124;
        #2 check_eq("pp_insert", 32'(pifo_insert), 32'd1);
        check_eq("pp_rank", 32'(pifo_rank), 32'd20);
        tick();
        in_valid = 1'b0;
        #2 check_eq("pp_occ4", 32'(occupancy), 32'd4);
        drain(21, 4);
        #2 check_eq("pp_empty", 32'(occupancy), 32'd0);
        tick();

        // stream across pointer wrap with random backpressure
        sent = 0; got_cnt = 0;
        for (int cyc = 0; cyc < 300 && (sent < 20 || q.size() > 0); cyc++) begin
            in_valid  = (sent < 20);
            in_rank   = 10'(200 + sent);
            in_meta   = 20'($urandom);
            pifo_busy = 1'($urandom_range(0, 1));
            #2;
            check_eq("st_ready", 32'(in_ready), 32'(q.size() < 8));
            exp_ins = (q.size() > 0) && !pifo_busy;
            check_eq("st_insert", 32'(pifo_insert), 32'(exp_ins));
            if (in_valid && q.size() < 8) begin
                q.push_back({in_rank, in_meta});
                sent++;
            end
            if (exp_ins && pifo_insert) begin
                ent = q.pop_front();
                check_eq("st_rank", 32'(pifo_rank), 32'(ent[29:20]));
                check_eq("st_meta", 32'(pifo_meta), 32'(ent[19:0]));
                got_cnt++;
            end
            tick();
        end
        in_valid = 1'b0; pifo_busy = 1'b0;
        check_eq("st_count", 32'(got_cnt), 32'd20);

        // mid-stream reset discards entries and counters
        pifo_busy = 1'b1;
        fill(300, 3);
        rst = 1'b1; in_valid = 1'b1; in_rank = 10'd400;
        tick();
        rst = 1'b0; in_valid = 1'b0; pifo_busy = 1'b0;
        #2 check_eq("mr_insert", 32'(pifo_insert), 32'd0);
        check_eq("mr_occ", 32'(occupancy), 32'd0);
        check_eq("mr_drop", 32'(drop_cnt), 32'd0);
        check_eq("mr_max", 32'(max_occ), 32'd0);
        check_eq("mr_rank", 32'(pifo_rank), 32'd0);
        tick();
        #2 check_eq("mr_insert2", 32'(pifo_insert), 32'd0);
        tick();

        // drop counter saturation
        pifo_busy = 1'b1; drop_en = 1'b1;
        fill(500, 8);
        in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        #2 check_eq("sat_drop", 32'(drop_cnt), 32'hFFFF);
        check_eq("sat_occ", 32'(occupancy), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
